// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: walks each instruction through FETCH, DECODE,
// EXEC, MEM and WB, driving the datapath control bundle, bus timeouts and traps.
module multicycle_control #(
    parameter int EXT_OPS = 1,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    input  logic             trap_clear,
    output logic [2:0]       imm_sel,
    output logic             op1sel,
    output logic             op2sel,
    output logic [3:0]       read_write,
    output logic [2:0]       branch_jump,
    output logic             reg_write_en,
    output logic             ir_load,
    output logic             pc_write,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    localparam int TW = $clog2(TIMEOUT + 2);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t          state, state_nx;
    logic [6:0]      opcode;
    logic [TW-1:0]   tcnt;
    logic [1:0]      cause_nx;
    logic            retire;
    logic            legal;
    logic            waiting;
    logic            timed_out;

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_R, OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_JAL: legal = 1'b1;
            OP_LUI, OP_AUIPC, OP_JALR:                          legal = (EXT_OPS != 0);
            default:                                            legal = 1'b0;
        endcase
    end

    // The timeout fires on the TIMEOUT-th consecutive waiting cycle, counted inclusively.
    assign waiting   = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
    assign timed_out = (TIMEOUT != 0) && waiting && (tcnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        cause_nx = trap_cause;
        retire   = 1'b0;
        case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    state_nx = S_DECODE;
                end else if (timed_out) begin
                    state_nx = S_TRAP;
                    cause_nx = 2'b10;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_nx = S_EXEC;
                end else begin
                    state_nx = S_TRAP;
                    cause_nx = 2'b01;
                end
            end
            S_EXEC: begin
                if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
                    state_nx = S_MEM;
                end else if (opcode == OP_BRANCH) begin
                    state_nx = S_FETCH;
                    retire   = 1'b1;
                end else begin
                    state_nx = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (opcode == OP_STORE) begin
                        state_nx = S_FETCH;
                        retire   = 1'b1;
                    end else begin
                        state_nx = S_WB;
                    end
                end else if (timed_out) begin
                    state_nx = S_TRAP;
                    cause_nx = 2'b10;
                end
            end
            S_WB: begin
                state_nx = S_FETCH;
                retire   = 1'b1;
            end
            S_TRAP: begin
                if (trap_clear) begin
                    state_nx = S_FETCH;
                    cause_nx = 2'b00;
                end
            end
            default: state_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            opcode     <= 7'd0;
            tcnt       <= '0;
            trap_cause <= 2'b00;
            retired    <= '0;
        end else begin
            state      <= state_nx;
            trap_cause <= cause_nx;
            if ((state == S_FETCH) && mem_ready) begin
                opcode <= instr[6:0];
            end
            if (state_nx != state) begin
                tcnt <= '0;
            end else if (waiting) begin
                tcnt <= tcnt + TW'(1);
            end
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        imm_sel      = 3'b000;
        op1sel       = 1'b0;
        op2sel       = 1'b0;
        read_write   = 4'b0000;
        branch_jump  = 3'b000;
        reg_write_en = 1'b0;
        ir_load      = 1'b0;
        pc_write     = 1'b0;
        trap         = 1'b0;
        case (state)
            S_FETCH: begin
                read_write = 4'b0100;
                ir_load    = mem_ready;
            end
            S_EXEC: begin
                case (opcode)
                    OP_IMM, OP_LOAD: op2sel = 1'b1;
                    OP_STORE: begin
                        imm_sel = 3'b001;
                        op2sel  = 1'b1;
                    end
                    OP_BRANCH: begin
                        imm_sel     = 3'b010;
                        branch_jump = 3'b001;
                        pc_write    = 1'b1;
                    end
                    OP_JAL: begin
                        imm_sel     = 3'b011;
                        branch_jump = 3'b010;
                    end
                    OP_JALR: begin
                        op2sel      = 1'b1;
                        branch_jump = 3'b011;
                    end
                    OP_LUI: begin
                        imm_sel = 3'b100;
                        op2sel  = 1'b1;
                    end
                    OP_AUIPC: begin
                        imm_sel = 3'b100;
                        op1sel  = 1'b1;
                        op2sel  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                op2sel = 1'b1;
                // Store PC update is qualified by mem_ready so it pulses once per instruction.
                if (opcode == OP_STORE) begin
                    imm_sel    = 3'b001;
                    read_write = 4'b0010;
                    pc_write   = mem_ready;
                end else begin
                    read_write = 4'b0001;
                end
            end
            S_WB: begin
                reg_write_en = 1'b1;
                pc_write     = 1'b1;
                if (opcode == OP_JAL) begin
                    branch_jump = 3'b010;
                end else if (opcode == OP_JALR) begin
                    branch_jump = 3'b011;
                end
            end
            S_TRAP: trap = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two configurations driven one at a time, every cycle
// checked against an instruction-level reference model.
module tb_multicycle_control;

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] imm;
        logic       op1;
        logic       op2;
        logic [3:0] rw;
        logic [2:0] bj;
        logic       rwe;
        logic       irl;
        logic       pcw;
        logic       trp;
        logic [1:0] cause;
    } obs_t;

    localparam int CL_R = 0, CL_I = 1, CL_LD = 2, CL_ST = 3, CL_BR = 4;
    localparam int CL_JAL = 5, CL_JALR = 6, CL_LUI = 7, CL_AUIPC = 8, CL_ILL = 9;
    localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4, PH_T = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic [31:0] instr;
    logic        mem_ready;
    logic        trap_clear;

    logic [2:0]  imm_a, bj_a, st_a, imm_b, bj_b, st_b;
    logic        op1_a, op2_a, rwe_a, irl_a, pcw_a, trp_a;
    logic        op1_b, op2_b, rwe_b, irl_b, pcw_b, trp_b;
    logic [3:0]  rw_a, rw_b;
    logic [1:0]  cause_a, cause_b;
    logic [31:0] ret_a;
    logic [3:0]  ret_b;

    obs_t        obs;
    logic [31:0] obs_ret;

    int errors = 0;
    int checks = 0;
    int exp_ret_a = 0;
    int exp_ret_b = 0;

    always #5 clk = ~clk;

    multicycle_control #(.EXT_OPS(1), .TIMEOUT(4), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .instr(instr),
        .mem_ready(mem_ready & ~sel), .trap_clear(trap_clear & ~sel),
        .imm_sel(imm_a), .op1sel(op1_a), .op2sel(op2_a), .read_write(rw_a),
        .branch_jump(bj_a), .reg_write_en(rwe_a), .ir_load(irl_a), .pc_write(pcw_a),
        .trap(trp_a), .trap_cause(cause_a), .state_o(st_a), .retired(ret_a)
    );

    multicycle_control #(.EXT_OPS(0), .TIMEOUT(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .instr(instr),
        .mem_ready(mem_ready & sel), .trap_clear(trap_clear & sel),
        .imm_sel(imm_b), .op1sel(op1_b), .op2sel(op2_b), .read_write(rw_b),
        .branch_jump(bj_b), .reg_write_en(rwe_b), .ir_load(irl_b), .pc_write(pcw_b),
        .trap(trp_b), .trap_cause(cause_b), .state_o(st_b), .retired(ret_b)
    );

    always_comb begin
        if (sel) begin
            obs     = {st_b, imm_b, op1_b, op2_b, rw_b, bj_b, rwe_b, irl_b, pcw_b, trp_b, cause_b};
            obs_ret = {28'd0, ret_b};
        end else begin
            obs     = {st_a, imm_a, op1_a, op2_a, rw_a, bj_a, rwe_a, irl_a, pcw_a, trp_a, cause_a};
            obs_ret = ret_a;
        end
    end

    function automatic int classify(input logic [6:0] op, input bit ext);
        case (op)
            7'b0110011: return CL_R;
            7'b0010011: return CL_I;
            7'b0000011: return CL_LD;
            7'b0100011: return CL_ST;
            7'b1100011: return CL_BR;
            7'b1101111: return CL_JAL;
            7'b1100111: return ext ? CL_JALR : CL_ILL;
            7'b0110111: return ext ? CL_LUI : CL_ILL;
            7'b0010111: return ext ? CL_AUIPC : CL_ILL;
            default:    return CL_ILL;
        endcase
    endfunction

    // Expected control bundle for an instruction class in a given phase.
    function automatic obs_t model(input int cl, input int ph, input logic mr, input logic [1:0] cause);
        obs_t o;
        o = '0;
        o.st = 3'(ph);
        o.cause = cause;
        if (ph == PH_F) begin
            o.rw  = 4'b0100;
            o.irl = mr;
        end else if (ph == PH_E) begin
            case (cl)
                CL_I, CL_LD: o.op2 = 1'b1;
                CL_ST:       begin o.imm = 3'b001; o.op2 = 1'b1; end
                CL_BR:       begin o.imm = 3'b010; o.bj = 3'b001; o.pcw = 1'b1; end
                CL_JAL:      begin o.imm = 3'b011; o.bj = 3'b010; end
                CL_JALR:     begin o.op2 = 1'b1; o.bj = 3'b011; end
                CL_LUI:      begin o.imm = 3'b100; o.op2 = 1'b1; end
                CL_AUIPC:    begin o.imm = 3'b100; o.op1 = 1'b1; o.op2 = 1'b1; end
                default: ;
            endcase
        end else if (ph == PH_M) begin
            o.op2 = 1'b1;
            if (cl == CL_ST) begin
                o.imm = 3'b001;
                o.rw  = 4'b0010;
                o.pcw = mr;
            end else begin
                o.rw = 4'b0001;
            end
        end else if (ph == PH_W) begin
            o.rwe = 1'b1;
            o.pcw = 1'b1;
            if (cl == CL_JAL)  o.bj = 3'b010;
            if (cl == CL_JALR) o.bj = 3'b011;
        end else if (ph == PH_T) begin
            o.trp = 1'b1;
        end
        return o;
    endfunction

    task automatic check(input string tag, input obs_t e);
        logic [31:0] er;
        er = sel ? 32'(exp_ret_b % 16) : 32'(exp_ret_a);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, e);
        end
        checks++;
        assert (obs_ret === er) else begin
            errors++;
            $error("FAIL %s_retired: got %0d expected %0d", tag, obs_ret, er);
        end
    endtask

    task automatic step(input string tag, input obs_t e);
        @(negedge clk);
        check(tag, e);
        @(posedge clk);
        #1;
    endtask

    task automatic retire_one();
        if (sel) exp_ret_b++;
        else     exp_ret_a++;
    endtask

    task automatic do_trap(input logic [1:0] cause, input int hold);
        for (int i = 0; i <= hold; i++) begin
            trap_clear = (i == hold);
            mem_ready  = 1'($urandom);
            step("trap", model(CL_ILL, PH_T, 1'b0, cause));
        end
        trap_clear = 1'b0;
    endtask

    // Drives one instruction: fw wait cycles before fetch completes, mw in MEM.
    task automatic run_instr(input logic [31:0] w, input int fw, input int mw);
        int   cl;
        int   tmo;
        logic mr;
        tmo = sel ? 0 : 4;
        cl  = classify(w[6:0], !sel);
        for (int i = 0; i <= fw; i++) begin
            mr        = (i == fw);
            mem_ready = mr;
            instr     = mr ? w : $urandom;
            step("fetch", model(cl, PH_F, mr, 2'b00));
            if (!mr && tmo != 0 && i == tmo - 1) begin
                do_trap(2'b10, $urandom_range(0, 2));
                return;
            end
        end
        mem_ready = 1'($urandom);
        instr     = $urandom;
        step("decode", model(cl, PH_D, 1'b0, 2'b00));
        if (cl == CL_ILL) begin
            do_trap(2'b01, $urandom_range(0, 2));
            return;
        end
        step("exec", model(cl, PH_E, 1'b0, 2'b00));
        if (cl == CL_BR) begin
            retire_one();
            return;
        end
        if (cl == CL_LD || cl == CL_ST) begin
            for (int j = 0; j <= mw; j++) begin
                mr        = (j == mw);
                mem_ready = mr;
                step("mem", model(cl, PH_M, mr, 2'b00));
                if (!mr && tmo != 0 && j == tmo - 1) begin
                    do_trap(2'b10, $urandom_range(0, 2));
                    return;
                end
            end
            if (cl == CL_ST) begin
                retire_one();
                return;
            end
        end
        mem_ready = 1'($urandom);
        step("wb", model(cl, PH_W, 1'b0, 2'b00));
        retire_one();
    endtask

    function automatic logic [31:0] rand_word();
        logic [6:0]  ops [9];
        logic [31:0] r;
        int          idx;
        ops = '{7'b0110011, 7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b0110111, 7'b0010111, 7'b1100111};
        r   = $urandom;
        idx = $urandom_range(0, 10);
        if (idx < 9) r[6:0] = ops[idx];
        return r;
    endfunction

    initial begin
        rst_n      = 1'b0;
        sel        = 1'b0;
        instr      = 32'd0;
        mem_ready  = 1'b0;
        trap_clear = 1'b0;
        #3;
        check("reset", model(CL_ILL, PH_F, 1'b0, 2'b00));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed cases on the extended-ops, TIMEOUT=4 configuration.
        run_instr(32'h002081B3, 0, 0);
        run_instr(32'h0000A103, 0, 3);
        run_instr(32'h00208463, 1, 0);
        run_instr(32'h123450B7, 0, 0);
        run_instr(32'h00000517, 2, 0);
        run_instr(32'h000080E7, 0, 0);
        run_instr(32'h0100006F, 0, 0);
        run_instr(32'h0020A423, 0, 2);
        run_instr(32'h002081B3, 4, 0);
        run_instr(32'h002081B3, 3, 0);
        run_instr(32'h0000A103, 0, 4);
        run_instr(32'h0000A103, 0, 3);
        run_instr(32'hFFFFFFFF, 0, 0);

        for (int n = 0; n < 40; n++) begin
            run_instr(rand_word(), $urandom_range(0, 5), $urandom_range(0, 5));
        end

        // Asynchronous reset in the middle of a store's memory phase.
        mem_ready = 1'b1;
        instr     = 32'h0020A423;
        step("rst_fetch", model(CL_ST, PH_F, 1'b1, 2'b00));
        step("rst_decode", model(CL_ST, PH_D, 1'b0, 2'b00));
        step("rst_exec", model(CL_ST, PH_E, 1'b0, 2'b00));
        mem_ready = 1'b0;
        step("rst_mem", model(CL_ST, PH_M, 1'b0, 2'b00));
        #2;
        rst_n     = 1'b0;
        exp_ret_a = 0;
        exp_ret_b = 0;
        #1;
        check("rst_async", model(CL_ST, PH_F, 1'b0, 2'b00));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_instr(32'h0020A423, 0, 1);

        // EXT_OPS=0, timeout disabled, 4-bit retired counter.
        sel = 1'b1;
        run_instr(32'h123450B7, 0, 0);
        run_instr(32'h0000A103, 2, 20);
        run_instr(32'h002081B3, 9, 0);
        for (int n = 0; n < 18; n++) begin
            run_instr(32'h002081B3, $urandom_range(0, 2), 0);
        end
        for (int n = 0; n < 30; n++) begin
            run_instr(rand_word(), $urandom_range(0, 8), $urandom_range(0, 8));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multi-cycle successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states.
- Drives the same control bundle (imm_sel, op1sel, op2sel, read_write, branch_jump, reg_write_en) plus PC/IR strobes.
- Adds optional U-type/JALR support, memory handshaking with timeout, trap handling and a retired-instruction counter.

Parameters:
- EXT_OPS, 1, 1 = LUI/AUIPC/JALR legal; 0 = those opcodes trap as illegal.
- TIMEOUT, 16, max cycles waiting for mem_ready in FETCH/MEM before bus-timeout trap; 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  memory read data; valid when mem_ready=1 in FETCH.
- mem_ready  in  1  memory completes the current access this cycle.
- trap_clear  in  1  leave TRAP; ignored in all other states.
- imm_sel  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- op1sel  out  1  0 rs1, 1 PC.
- op2sel  out  1  0 rs2, 1 immediate.
- read_write  out  4  0000 none, 0001 load, 0010 store, 0100 fetch.
- branch_jump  out  3  000 none, 001 branch, 010 JAL, 011 JALR.
- reg_write_en  out  1  register-file write strobe, WB only.
- ir_load  out  1  latch instr into IR (= FETCH & mem_ready).
- pc_write  out  1  PC update strobe.
- trap  out  1  high while in TRAP.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 bus timeout; held until trap_clear.
- state_o  out  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 5.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (async, rst_n=0): state=FETCH, opcode register=0, timeout counter=0, trap_cause=00, retired=0. All strobes and control outputs are 0, except read_write=0100 because state is FETCH. Outputs take these values immediately on reset assertion, including mid-MEM.
- Outputs are decoded from the registered state and opcode register only. The sole exception is ir_load, which also depends on mem_ready.
- FETCH:
  - read_write=0100.
  - On mem_ready=1: ir_load=1, capture instr[6:0] into the opcode register, go to DECODE.
- DECODE (1 cycle):
  - Legal opcodes: 0110011, 0000011, 0010011, 0100011, 1100011, 1101111; with EXT_OPS=1 also 0110111, 0010111, 1100111.
  - Legal: go to EXEC. Otherwise: go to TRAP, trap_cause=01.
- EXEC (1 cycle), control outputs per opcode:
  - R: op2sel=0.
  - I-ALU and load: imm_sel=000, op2sel=1.
  - Store: imm_sel=001, op2sel=1.
  - Branch: imm_sel=010, branch_jump=001, pc_write=1.
  - JAL: imm_sel=011, branch_jump=010.
  - JALR: imm_sel=000, op2sel=1, branch_jump=011.
  - LUI: imm_sel=100, op2sel=1.
  - AUIPC: imm_sel=100, op1sel=1, op2sel=1.
- EXEC next state: load/store go to MEM; branch goes to FETCH (retired+1); all others go to WB.
- MEM:
  - read_write=0001 for load, 0010 for store; imm_sel and op2sel are held from EXEC.
  - On mem_ready: load goes to WB; store goes to FETCH with pc_write=1 and retired+1.
- WB (1 cycle):
  - reg_write_en=1 and pc_write=1; branch_jump is held for JAL/JALR.
  - Go to FETCH; retired+1.
- Timeout:
  - The counter increments each cycle in FETCH/MEM while mem_ready=0, and clears on any state change.
  - When TIMEOUT≠0 and the count reaches TIMEOUT with mem_ready=0: go to TRAP, trap_cause=10.
  - If mem_ready=1 on that same cycle, mem_ready wins and no trap is taken.
- TRAP:
  - trap=1; all other strobes are 0; read_write=0000.
  - trap_clear=1: go to FETCH, trap_cause=00, counter cleared. PC is not advanced.
- retired wraps modulo 2^CNT_W. It does not increment on any trapped instruction.
- Each pc_write and reg_write_en pulse is exactly one cycle per instruction.
- State encodings 6–7 are unreachable; if entered, the next state is FETCH.

Test Plan:
- R-type 0x002081B3, mem_ready=1 immediately → states 0,1,2,4,0; reg_write_en and pc_write high in the WB cycle only; retired=1.
- Load 0x0000A103, mem_ready delayed 3 cycles in MEM → read_write=0001 held for 4 cycles; WB follows; instruction takes 8 cycles total; retired=1.
- Branch 0x00208463 → EXEC shows imm_sel=010, branch_jump=001, pc_write=1; returns to FETCH without WB; reg_write_en never asserted.
- With EXT_OPS=0, LUI 0x123450B7 → TRAP after DECODE, trap_cause=01, retired unchanged. trap_clear → FETCH, trap_cause=00. With EXT_OPS=1, same word: imm_sel=100, WB reached.
- TIMEOUT=4, mem_ready held 0 in FETCH → TRAP on the 4th waiting cycle, trap_cause=10. Repeat with mem_ready=1 on the 4th cycle → DECODE, no trap.
- rst_n dropped mid-MEM of a store → immediately state_o=0, read_write=0100, retired=0, trap_cause=00; normal fetch resumes after release.
